// File: rtl/ctrl_oneshot_bank_pkg.sv
// rtl/ctrl_oneshot_bank_pkg.sv - shared state, edge-select constants and trigger helper for the one-shot bank
package ctrl_oneshot_bank_pkg;

    localparam int MAX_CHANNELS = 8;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    typedef enum logic [1:0] {
        ONESHOT_IDLE  = 2'd0,
        ONESHOT_PULSE = 2'd1,
        ONESHOT_HOLD  = 2'd2
    } oneshot_state_e;

    function automatic logic [MAX_CHANNELS-1:0] select_trig(
        input int                      edge_sel,
        input logic [MAX_CHANNELS-1:0] cur,
        input logic [MAX_CHANNELS-1:0] prev
    );
        logic [MAX_CHANNELS-1:0] rise;
        logic [MAX_CHANNELS-1:0] fall;
        rise = cur & ~prev;
        fall = ~cur & prev;
        case (edge_sel)
            EDGE_RISE: return rise;
            EDGE_FALL: return fall;
            default:   return rise | fall;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_oneshot_chan.sv
// rtl/ctrl_oneshot_chan.sv - single one-shot channel: IDLE/PULSE/HOLD FSM, down-counter and sticky overrun
module ctrl_oneshot_chan
    import ctrl_oneshot_bank_pkg::*;
#(
    parameter int CountWidth = 16,
    parameter int PulseWidth = 16,
    parameter int HoldOff    = 0,
    parameter int Retrigger  = 0
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic enable_i,
    input  logic trig_i,
    input  logic clear_overrun_i,
    output logic pulse_out_o,
    output logic busy_o,
    output logic overrun_o
);

    localparam logic [CountWidth-1:0] PULSE_LOAD = CountWidth'(PulseWidth - 1);
    localparam logic [CountWidth-1:0] HOLD_LOAD  = CountWidth'((HoldOff > 0) ? HoldOff - 1 : 0);
    localparam logic [CountWidth-1:0] CNT_ONE    = CountWidth'(1);

    oneshot_state_e        state_q;
    logic [CountWidth-1:0] cnt_q;
    logic                  pulse_q;
    logic                  busy_q;
    logic                  overrun_q;
    logic                  lost_trig;

    // A trigger that cannot start or extend a pulse is lost, including one on the last cycle of a phase.
    assign lost_trig = enable_i && trig_i &&
                       ((state_q == ONESHOT_HOLD) ||
                        ((state_q == ONESHOT_PULSE) && (Retrigger == 0)));

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ONESHOT_IDLE;
            cnt_q     <= '0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (lost_trig) begin
                overrun_q <= 1'b1;
            end else if (clear_overrun_i) begin
                overrun_q <= 1'b0;
            end

            if (!enable_i) begin
                state_q <= ONESHOT_IDLE;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ONESHOT_IDLE: begin
                        if (trig_i) begin
                            state_q <= ONESHOT_PULSE;
                            cnt_q   <= PULSE_LOAD;
                            pulse_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                    ONESHOT_PULSE: begin
                        if (trig_i && (Retrigger != 0)) begin
                            cnt_q <= PULSE_LOAD;
                        end else if (cnt_q == '0) begin
                            if (HoldOff > 0) begin
                                state_q <= ONESHOT_HOLD;
                                cnt_q   <= HOLD_LOAD;
                                pulse_q <= 1'b0;
                            end else begin
                                state_q <= ONESHOT_IDLE;
                                pulse_q <= 1'b0;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    ONESHOT_HOLD: begin
                        if (cnt_q == '0) begin
                            state_q <= ONESHOT_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= ONESHOT_IDLE;
                        cnt_q   <= '0;
                        pulse_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pulse_out_o = pulse_q;
    assign busy_o      = busy_q;
    assign overrun_o   = overrun_q;

endmodule

// File: rtl/ctrl_oneshot_bank.sv
// rtl/ctrl_oneshot_bank.sv - bank of edge-triggered one-shot channels fed by the 8-bit control register
module ctrl_oneshot_bank
    import ctrl_oneshot_bank_pkg::*;
#(
    parameter int NumChannels = 8,
    parameter int CountWidth  = 16,
    parameter int PulseWidth  = 16,
    parameter int HoldOff     = 0,
    parameter int TriggerEdge = 0,
    parameter int Retrigger   = 0
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic [MAX_CHANNELS-1:0] control_in_i,
    input  logic [MAX_CHANNELS-1:0] clear_overrun_i,
    output logic [MAX_CHANNELS-1:0] pulse_out_o,
    output logic [MAX_CHANNELS-1:0] busy_o,
    output logic [MAX_CHANNELS-1:0] overrun_o
);

    localparam longint CntMax = (longint'(1) << CountWidth) - 1;

    if (NumChannels < 1 || NumChannels > MAX_CHANNELS ||
        CountWidth < 1 || CountWidth > 32 ||
        PulseWidth < 1 || longint'(PulseWidth) > CntMax ||
        HoldOff < 0 || longint'(HoldOff) > CntMax ||
        TriggerEdge < EDGE_RISE || TriggerEdge > EDGE_BOTH ||
        Retrigger < 0 || Retrigger > 1) begin : g_bad_param
        $fatal(1, "ctrl_oneshot_bank: parameter out of range");
    end

    logic [MAX_CHANNELS-1:0] prev_q;
    logic [MAX_CHANNELS-1:0] trig;

    // prev tracks through reset and disable so no stale level fires on release.
    always_ff @(posedge clock_i) begin
        prev_q <= control_in_i;
    end

    assign trig = select_trig(TriggerEdge, control_in_i, prev_q);

    for (genvar i = 0; i < MAX_CHANNELS; i++) begin : g_chan
        if (i < NumChannels) begin : g_on
            ctrl_oneshot_chan #(
                .CountWidth (CountWidth),
                .PulseWidth (PulseWidth),
                .HoldOff    (HoldOff),
                .Retrigger  (Retrigger)
            ) u_chan (
                .clock_i         (clock_i),
                .reset_i         (reset_i),
                .enable_i        (enable_i),
                .trig_i          (trig[i]),
                .clear_overrun_i (clear_overrun_i[i]),
                .pulse_out_o     (pulse_out_o[i]),
                .busy_o          (busy_o[i]),
                .overrun_o       (overrun_o[i])
            );
        end else begin : g_off
            assign pulse_out_o[i] = 1'b0;
            assign busy_o[i]      = 1'b0;
            assign overrun_o[i]   = 1'b0;
        end
    end

endmodule

// File: tb/tb_ctrl_oneshot_bank.sv
// tb/tb_ctrl_oneshot_bank.sv - directed and randomized bench for ctrl_oneshot_bank with an interval-based reference model
module tb_ctrl_oneshot_bank;

    localparam int NI = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [7:0] ctrl = 8'h00;
    logic [7:0] clr = 8'h00;
    logic [7:0] po [NI];
    logic [7:0] bo [NI];
    logic [7:0] oo [NI];

    int p_pw [NI] = '{4, 4, 4, 4, 4};
    int p_ho [NI] = '{0, 3, 0, 0, 2};
    int p_te [NI] = '{0, 0, 2, 1, 0};
    int p_rt [NI] = '{0, 0, 1, 0, 0};
    int p_nc [NI] = '{8, 8, 8, 8, 3};

    // Model: each channel is a pulse window [start, pend] and busy window [start, bend] in cycle numbers.
    int         m_start [NI][8];
    int         m_pend  [NI][8];
    int         m_bend  [NI][8];
    bit         m_ovr   [NI][8];
    logic [7:0] m_prev = 8'h00;

    int cyc = 0;
    int base = 0;
    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ctrl_oneshot_bank #(.NumChannels(8), .CountWidth(16), .PulseWidth(4), .HoldOff(0), .TriggerEdge(0), .Retrigger(0)) u_a (
        .clock_i(clock), .reset_i(reset), .enable_i(enable), .control_in_i(ctrl), .clear_overrun_i(clr),
        .pulse_out_o(po[0]), .busy_o(bo[0]), .overrun_o(oo[0]));
    ctrl_oneshot_bank #(.NumChannels(8), .CountWidth(16), .PulseWidth(4), .HoldOff(3), .TriggerEdge(0), .Retrigger(0)) u_b (
        .clock_i(clock), .reset_i(reset), .enable_i(enable), .control_in_i(ctrl), .clear_overrun_i(clr),
        .pulse_out_o(po[1]), .busy_o(bo[1]), .overrun_o(oo[1]));
    ctrl_oneshot_bank #(.NumChannels(8), .CountWidth(16), .PulseWidth(4), .HoldOff(0), .TriggerEdge(2), .Retrigger(1)) u_c (
        .clock_i(clock), .reset_i(reset), .enable_i(enable), .control_in_i(ctrl), .clear_overrun_i(clr),
        .pulse_out_o(po[2]), .busy_o(bo[2]), .overrun_o(oo[2]));
    ctrl_oneshot_bank #(.NumChannels(8), .CountWidth(16), .PulseWidth(4), .HoldOff(0), .TriggerEdge(1), .Retrigger(0)) u_d (
        .clock_i(clock), .reset_i(reset), .enable_i(enable), .control_in_i(ctrl), .clear_overrun_i(clr),
        .pulse_out_o(po[3]), .busy_o(bo[3]), .overrun_o(oo[3]));
    ctrl_oneshot_bank #(.NumChannels(3), .CountWidth(16), .PulseWidth(4), .HoldOff(2), .TriggerEdge(0), .Retrigger(0)) u_e (
        .clock_i(clock), .reset_i(reset), .enable_i(enable), .control_in_i(ctrl), .clear_overrun_i(clr),
        .pulse_out_o(po[4]), .busy_o(bo[4]), .overrun_o(oo[4]));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Applies the inputs sampled at the end of cycle t.
    task automatic model_update(input int t);
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < p_nc[i]; c++) begin
                bit rise, fall, trig, in_pulse, in_busy, lost;
                rise = ctrl[c] && !m_prev[c];
                fall = !ctrl[c] && m_prev[c];
                trig = (p_te[i] == 0) ? rise : (p_te[i] == 1) ? fall : (rise || fall);
                in_pulse = (t >= m_start[i][c]) && (t <= m_pend[i][c]);
                in_busy  = (t >= m_start[i][c]) && (t <= m_bend[i][c]);
                lost = 1'b0;
                if (reset) begin
                    m_pend[i][c] = min_i(m_pend[i][c], t);
                    m_bend[i][c] = min_i(m_bend[i][c], t);
                    m_ovr[i][c]  = 1'b0;
                end else begin
                    if (!enable) begin
                        m_pend[i][c] = min_i(m_pend[i][c], t);
                        m_bend[i][c] = min_i(m_bend[i][c], t);
                    end else if (trig) begin
                        if (!in_busy) begin
                            m_start[i][c] = t + 1;
                            m_pend[i][c]  = t + p_pw[i];
                            m_bend[i][c]  = t + p_pw[i] + p_ho[i];
                        end else if (in_pulse && p_rt[i] == 1) begin
                            m_pend[i][c] = t + p_pw[i];
                            m_bend[i][c] = t + p_pw[i] + p_ho[i];
                        end else begin
                            lost = 1'b1;
                        end
                    end
                    if (lost) m_ovr[i][c] = 1'b1;
                    else if (clr[c]) m_ovr[i][c] = 1'b0;
                end
            end
        end
        m_prev = ctrl;
    endtask

    function automatic logic [7:0] exp_vec(input int i, input int sel, input int t);
        logic [7:0] v;
        v = 8'h00;
        for (int c = 0; c < 8; c++) begin
            case (sel)
                0:       v[c] = (t >= m_start[i][c]) && (t <= m_pend[i][c]);
                1:       v[c] = (t >= m_start[i][c]) && (t <= m_bend[i][c]);
                default: v[c] = m_ovr[i][c];
            endcase
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        model_update(cyc);
        cyc++;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("model_pulse_u%0d", i), po[i], exp_vec(i, 0, cyc));
            chk($sformatf("model_busy_u%0d", i), bo[i], exp_vec(i, 1, cyc));
            chk($sformatf("model_overrun_u%0d", i), oo[i], exp_vec(i, 2, cyc));
        end
    endtask

    task automatic go(input int k);
        while (cyc < base + k) step();
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < 8; c++) begin
                m_start[i][c] = 0;
                m_pend[i][c]  = -1;
                m_bend[i][c]  = -1;
                m_ovr[i][c]   = 1'b0;
            end
        end

        // Reset state
        step(); step(); step();
        chk("reset_pulse", po[0], 8'h00);
        chk("reset_busy", bo[1], 8'h00);
        chk("reset_overrun", oo[2], 8'h00);
        reset = 1'b0;

        // Basic pulse on u_a channel 0
        base = cyc;
        go(10); ctrl[0] = 1'b1;
        go(11); chk("basic_pulse_c11", {7'b0, po[0][0]}, 8'h01); chk("basic_busy_c11", {7'b0, bo[0][0]}, 8'h01);
        go(14); chk("basic_pulse_c14", {7'b0, po[0][0]}, 8'h01);
        go(15); chk("basic_pulse_c15", {7'b0, po[0][0]}, 8'h00); chk("basic_busy_c15", {7'b0, bo[0][0]}, 8'h00);
        chk("basic_overrun", {7'b0, oo[0][0]}, 8'h00);
        go(16); ctrl[0] = 1'b0;
        go(30);

        // Hold-off on u_b channel 2
        base = cyc;
        go(10); ctrl[2] = 1'b1;
        go(11); chk("hold_pulse_c11", {7'b0, po[1][2]}, 8'h01); chk("hold_busy_c11", {7'b0, bo[1][2]}, 8'h01);
        go(13); ctrl[2] = 1'b0;
        go(15); chk("hold_pulse_c15", {7'b0, po[1][2]}, 8'h00); chk("hold_busy_c15", {7'b0, bo[1][2]}, 8'h01);
        go(16); ctrl[2] = 1'b1;
        go(17); chk("hold_busy_c17", {7'b0, bo[1][2]}, 8'h01); chk("hold_overrun_c17", {7'b0, oo[1][2]}, 8'h01);
        go(18); chk("hold_busy_c18", {7'b0, bo[1][2]}, 8'h00); ctrl[2] = 1'b0;
        go(20); ctrl[2] = 1'b1;
        go(21); chk("hold_repulse_c21", {7'b0, po[1][2]}, 8'h01);
        go(24); chk("hold_repulse_c24", {7'b0, po[1][2]}, 8'h01);
        go(25); chk("hold_repulse_c25", {7'b0, po[1][2]}, 8'h00);
        go(26); ctrl[2] = 1'b0; clr = 8'h04;
        go(27); clr = 8'h00; chk("hold_overrun_cleared", {7'b0, oo[1][2]}, 8'h00);
        go(40);

        // Retrigger on u_c channel 1, both edges
        base = cyc;
        go(10); ctrl[1] = 1'b1;
        go(11); chk("retrig_c11", {7'b0, po[2][1]}, 8'h01);
        go(12); chk("retrig_c12", {7'b0, po[2][1]}, 8'h01); ctrl[1] = 1'b0;
        for (int k = 13; k <= 16; k++) begin
            go(k); chk($sformatf("retrig_c%0d", k), {7'b0, po[2][1]}, 8'h01);
        end
        go(17); chk("retrig_c17", {7'b0, po[2][1]}, 8'h00); chk("retrig_overrun", {7'b0, oo[2][1]}, 8'h00);
        go(25);

        // Reset with all control bits high, then falling edge on all channels of u_d
        reset = 1'b1; ctrl = 8'hFF;
        step(); step();
        reset = 1'b0;
        base = cyc;
        go(5); chk("ff_release_rise", po[0], 8'h00); chk("ff_release_fall", po[3], 8'h00);
        ctrl = 8'h00;
        step(); chk("all_fall_pulse", po[3], 8'hFF);
        go(15);

        // Enable removed mid-pulse on u_a channel 3
        base = cyc;
        go(10); ctrl[3] = 1'b1;
        go(11); chk("en_pulse_c11", {7'b0, po[0][3]}, 8'h01);
        go(12); enable = 1'b0;
        go(13); ctrl[3] = 1'b0;
        go(14); chk("en_pulse_c14", {7'b0, po[0][3]}, 8'h00); chk("en_busy_c14", {7'b0, bo[0][3]}, 8'h00);
        go(15); ctrl[3] = 1'b1;
        go(16); chk("dis_pulse_c16", {7'b0, po[0][3]}, 8'h00); chk("dis_overrun_c16", {7'b0, oo[0][3]}, 8'h00);
        go(20); enable = 1'b1;
        for (int k = 21; k <= 24; k++) begin
            go(k); chk($sformatf("reen_pulse_c%0d", k), {7'b0, po[0][3]}, 8'h00);
        end

        // NumChannels=3 on u_e: upper channels inert; set beats clear
        base = cyc;
        for (int k = 1; k <= 6; k++) begin
            go(k); ctrl[7:3] = ~ctrl[7:3];
        end
        go(8);
        chk("inert_pulse", po[4] & 8'hF8, 8'h00);
        chk("inert_busy", bo[4] & 8'hF8, 8'h00);
        chk("inert_overrun", oo[4] & 8'hF8, 8'h00);
        go(10); ctrl[0] = 1'b1;
        go(12); ctrl[0] = 1'b0;
        go(13); ctrl[0] = 1'b1; clr = 8'h01;
        go(14); clr = 8'h00; chk("set_beats_clear", {7'b0, oo[4][0]}, 8'h01);
        go(20);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            ctrl   = ctrl ^ ($urandom & $urandom & $urandom);
            enable = ($urandom_range(0, 19) != 0);
            clr    = $urandom & $urandom & $urandom;
            reset  = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0; enable = 1'b1; clr = 8'h00;
        for (int n = 0; n < 10; n++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
